// File: rtl/pipe_bus_ctrl.sv
// Pipeline stall control and single-port memory bus arbiter (IF vs MEM) for the 5-stage MIPS32 core.
// Optional macro BUS_TIMEOUT_EN adds a TW-bit ack timeout that aborts a transfer after TIMEOUT cycles.
`timescale 1ns/1ps

module pipe_bus_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_sel,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic [31:0] mem_rdata,
  output logic        mem_valid,
  output logic        bus_err,
  output logic [5:0]  stall
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_IF_ACC  = 2'd1;
  localparam logic [1:0] S_MEM_ACC = 2'd2;

  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  logic [1:0]  state_q,     state_d;
  logic        bus_req_q,   bus_req_d;
  logic        bus_we_q,    bus_we_d;
  logic [31:0] bus_addr_q,  bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_sel_q,   bus_sel_d;
  logic [31:0] if_rdata_q,  if_rdata_d;
  logic        if_valid_q,  if_valid_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        mem_valid_q, mem_valid_d;

  logic        xfer_abort;
  logic        xfer_done;
  logic [31:0] xfer_data;
  logic        wait_mem;
  logic        wait_if;

`ifdef BUS_TIMEOUT_EN
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          bus_err_q, bus_err_d;
  logic          in_xfer;

  assign in_xfer    = (state_q == S_IF_ACC) || (state_q == S_MEM_ACC);
  // Abort on the cycle whose increment would reach TIMEOUT; a same-cycle ack wins.
  assign xfer_abort = in_xfer && !bus_ack && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d     = cnt_q;
    bus_err_d = 1'b0;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (in_xfer) begin
      if (!bus_ack) begin
        cnt_d = cnt_q + 1'b1;
      end
      bus_err_d = xfer_abort;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign xfer_abort = 1'b0;
  assign bus_err    = 1'b0;
`endif

  assign xfer_done = bus_ack || xfer_abort;
  assign xfer_data = bus_ack ? bus_rdata : '0;

  // A requester in its valid cycle is not re-served, so its held req cannot restart the bus.
  assign wait_mem = mem_req && !mem_valid_q;
  assign wait_if  = if_req && !if_valid_q;

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_sel_d   = bus_sel_q;
    if_rdata_d  = if_rdata_q;
    if_valid_d  = 1'b0;
    mem_rdata_d = mem_rdata_q;
    mem_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (wait_mem) begin
          state_d     = S_MEM_ACC;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we;
          bus_addr_d  = mem_addr;
          bus_wdata_d = mem_wdata;
          bus_sel_d   = mem_sel;
        end else if (wait_if) begin
          state_d    = S_IF_ACC;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = if_addr;
          bus_sel_d  = 4'b1111;
        end
      end

      S_IF_ACC: begin
        if (xfer_done) begin
          state_d    = S_IDLE;
          bus_req_d  = 1'b0;
          bus_we_d   = 1'b0;
          if_rdata_d = xfer_data;
          if_valid_d = 1'b1;
        end
      end

      S_MEM_ACC: begin
        if (xfer_done) begin
          state_d     = S_IDLE;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          mem_valid_d = 1'b1;
          if (!bus_we_q) begin
            mem_rdata_d = xfer_data;
          end
        end
      end

      default: begin
        state_d   = S_IDLE;
        bus_req_d = 1'b0;
        bus_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_sel_q   <= '0;
      if_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      mem_rdata_q <= '0;
      mem_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_sel_q   <= bus_sel_d;
      if_rdata_q  <= if_rdata_d;
      if_valid_q  <= if_valid_d;
      mem_rdata_q <= mem_rdata_d;
      mem_valid_q <= mem_valid_d;
    end
  end

  always_comb begin
    if (wait_mem) begin
      stall = STALL_MEM;
    end else if (stallreq_ex) begin
      stall = STALL_EX;
    end else if (stallreq_id) begin
      stall = STALL_ID;
    end else if (wait_if) begin
      stall = STALL_IF;
    end else begin
      stall = STALL_NONE;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_sel   = bus_sel_q;
  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_valid = mem_valid_q;

endmodule

// File: doc/pipe_bus_ctrl.md
Name: pipe_bus_ctrl

Overview:
- Pipeline control unit and single-port memory bus arbiter for the 5-stage MIPS32 core.
- Shares one external memory bus between instruction fetch (IF) and data access (MEM stage).
- Sequences each bus transaction with a req/ack handshake.
- Merges bus wait conditions with the ID/EX stall requests into the 6-bit stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.

Parameters:
- TIMEOUT, 255: max cycles to wait for bus_ack before abort (used only with BUS_TIMEOUT_EN).
- TW, 8: width of timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- stallreq_id  in  1  ID stage stall request (load-use etc.)
- stallreq_ex  in  1  EX stage stall request (multi-cycle madd/msub/div)
- if_req  in  1  fetch request, held until if_valid
- if_addr  in  32  fetch address
- mem_req  in  1  data access request, held until mem_valid
- mem_we  in  1  1=store, 0=load
- mem_addr  in  32  data address
- mem_wdata  in  32  store data
- mem_sel  in  4  byte enables
- bus_ack  in  1  slave completes current transfer
- bus_rdata  in  32  slave read data, valid with bus_ack
- bus_req  out  1  transfer in progress
- bus_we  out  1  write strobe
- bus_addr  out  32  address
- bus_wdata  out  32  write data
- bus_sel  out  4  byte enables (4'b1111 for fetch)
- if_rdata  out  32  fetched instruction
- if_valid  out  1  one-cycle pulse, if_rdata valid
- mem_rdata  out  32  load data
- mem_valid  out  1  one-cycle pulse, mem_rdata valid
- bus_err  out  1  one-cycle abort pulse (BUS_TIMEOUT_EN only, else tied 0)
- stall  out  6  [0]pc [1]if [2]id [3]ex [4]mem [5]wb; 1=Stop

Behaviour:
- Reset: state=IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_sel=0; if_rdata=0, mem_rdata=0; if_valid=0, mem_valid=0, bus_err=0; counter=0.
- Reset mid-transaction: drops bus_req next edge and discards the transfer; no valid pulse.
- FSM states: IDLE, IF_ACC, MEM_ACC.
- IDLE:
  - mem_req & ~mem_valid -> MEM_ACC. Latch mem_we/addr/wdata/sel onto bus outputs, bus_req=1.
  - else if_req & ~if_valid -> IF_ACC. bus_addr=if_addr, bus_we=0, bus_sel=4'b1111, bus_req=1.
  - MEM wins when both request in the same cycle.
- IF_ACC / MEM_ACC:
  - Bus outputs held stable until bus_ack.
  - On ack: next edge bus_req=0, bus_we=0, state=IDLE.
  - IF_ACC ack latches bus_rdata into if_rdata and pulses if_valid.
  - MEM_ACC ack latches bus_rdata into mem_rdata only when ~bus_we (stores leave mem_rdata unchanged) and pulses mem_valid.
- Valid pulses last exactly one cycle.
- A requester still asserting req in its valid cycle is not re-served that cycle; a new transfer may begin the following cycle.
- Minimum latency: req to bus_req 1 cycle; ack to valid 1 cycle.
- bus_ack received in IDLE is ignored.
- Stall (combinational from registered state and inputs), highest priority first:
  - wait_mem = mem_req & ~mem_valid -> 6'b011111
  - stallreq_ex -> 6'b001111
  - stallreq_id -> 6'b000111
  - wait_if = if_req & ~if_valid -> 6'b000011 (ID receives a bubble)
  - else 6'b000000
- Stall is never asserted on wb (bit 5 always 0).

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - TW-bit counter clears on entry to IF_ACC/MEM_ACC and increments each cycle without bus_ack.
  - When the counter reaches TIMEOUT without ack: drop bus_req and return to IDLE.
  - Deliver rdata=0 with the normal valid pulse, and pulse bus_err in the same cycle.
  - Ack arriving in the same cycle as timeout takes precedence (normal completion, no bus_err).
- Undefined: no counter; FSM waits indefinitely; bus_err constant 0.

Test Plan:
- Fetch only: if_req=1, if_addr=0x0000_0100, ack 3 cycles after bus_req, bus_rdata=0x2401_0005.
  - Expect stall=000011 until if_valid; if_rdata=0x2401_0005; bus_sel=1111.
- Simultaneous requests: if_req and mem_req (load, addr 0x0000_0200) in the same cycle.
  - Expect MEM_ACC first, stall=011111; then IF_ACC; two separate valid pulses in order.
- Store: mem_we=1, addr 0x0000_0300, wdata 0xDEAD_BEEF, sel 0011, ack after 1 cycle.
  - Expect bus fields stable until ack; mem_valid pulse; mem_rdata unchanged.
- Priority: stallreq_ex=1 with stallreq_id=1 and idle bus -> stall=001111.
  - Then only stallreq_id=1 -> 000111.
- Reset mid-op: assert rst during MEM_ACC.
  - Expect next edge all outputs 0, state IDLE, no mem_valid pulse.
- BUS_TIMEOUT_EN, TIMEOUT=4: fetch with no ack.
  - Expect bus_req drops after 4 cycles; if_valid and bus_err pulse together; if_rdata=0.
